// File: rtl/scale_1d_stream_if.sv
`default_nettype none
// ============================================================================
//  Module      : scale_1d_stream_if
//  Description : AXI4-Stream pixel channel (valid/ready, data, user, last)
//                with master and slave views.
//  Revision    : 1.0 - initial release
// ============================================================================
interface scale_1d_stream_if #(
    parameter int C_PIXEL_WIDTH = 24
) ();
    logic                     tvalid;
    logic                     tready;
    logic [C_PIXEL_WIDTH-1:0] tdata;
    logic                     tuser;
    logic                     tlast;

    modport master (output tvalid, output tdata, output tuser, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tuser, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/scale_1d_stream.sv
`default_nettype none
// ============================================================================
//  Module      : scale_1d_stream
//  Description : Streaming 1-D nearest-neighbour line resampler. A source
//                line of S pixels becomes M output pixels; output j carries
//                source pixel ceil((j+1)*S/M)-1, chosen with two
//                cross-multiplied counters (s_cnt steps by M, m_cnt by S).
//  Revision    : 1.0 - initial release
// ============================================================================
module scale_1d_stream #(
    parameter int C_PIXEL_WIDTH = 24,
    parameter int C_S_WIDTH     = 10,
    parameter int C_M_WIDTH     = 12
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic [C_S_WIDTH-1:0] s_width,
    input  wire logic [C_M_WIDTH-1:0] m_width,
    scale_1d_stream_if.slave          s_axis,
    scale_1d_stream_if.master         m_axis,
    output logic      [C_M_WIDTH-1:0] m_index,
    output logic                      err_len
);

    // Counters hold at most S*M+S, which fits in the sum of both widths.
    localparam int C_CNT_W = C_S_WIDTH + C_M_WIDTH;

    logic                     r_hold_v;
    logic [C_PIXEL_WIDTH-1:0] r_hold_data;
    logic                     r_hold_user;
    logic [C_CNT_W-1:0]       r_s_cnt;
    logic [C_CNT_W-1:0]       r_m_cnt;
    logic [C_S_WIDTH-1:0]     r_s_idx;
    logic [C_M_WIDTH-1:0]     r_m_idx;
    logic [C_S_WIDTH-1:0]     r_s_l;
    logic [C_M_WIDTH-1:0]     r_m_l;
    logic                     r_err_len;

    logic                     w_m_valid;
    logic                     w_m_hs;
    logic                     w_last_out;
    logic                     w_line_end;
    logic                     w_rel_out;
    logic                     w_rel_drop;
    logic                     w_release;
    logic                     w_line_start;
    logic [C_S_WIDTH-1:0]     w_s_eff;
    logic [C_M_WIDTH-1:0]     w_m_eff;
    logic                     w_zero;
    logic                     w_s_ready;
    logic                     w_s_hs;
    logic [C_S_WIDTH-1:0]     w_s_idx_eff;
    logic [C_CNT_W-1:0]       w_s_cnt_base;
    logic [C_CNT_W-1:0]       w_s_l_ext;
    logic [C_CNT_W-1:0]       w_m_eff_ext;
    logic [C_CNT_W-1:0]       w_s_width_ext;
    logic                     w_bad_last;

    // Emit / release / ready decisions for the current cycle.
    always_comb begin
        w_s_l_ext     = {{C_M_WIDTH{1'b0}}, r_s_l};
        w_m_valid     = r_hold_v && (r_s_cnt >= r_m_cnt);
        w_m_hs        = w_m_valid && m_axis.tready;
        w_last_out    = (r_m_idx == (r_m_l - 1'b1));
        w_line_end    = w_m_hs && w_last_out;
        // Held pixel is not needed for the next output slot.
        w_rel_out     = w_m_hs && (r_s_cnt < (r_m_cnt + w_s_l_ext));
        // Held pixel maps to no output at all: drop it.
        w_rel_drop    = r_hold_v && (r_s_cnt < r_m_cnt);
        w_release     = w_rel_out || w_rel_drop;
        // A pixel accepted in the line-end cycle already opens the next line.
        w_line_start  = ((r_s_idx == '0) && (r_m_idx == '0)) || w_line_end;
        w_s_eff       = w_line_start ? s_width : r_s_l;
        w_m_eff       = w_line_start ? m_width : r_m_l;
        w_zero        = (w_s_eff == '0) || (w_m_eff == '0);
        w_s_ready     = !reset && (!r_hold_v || w_release) && !w_zero;
        w_s_hs        = s_axis.tvalid && w_s_ready;
        w_s_idx_eff   = w_line_start ? '0 : r_s_idx;
        w_s_cnt_base  = w_line_start ? '0 : r_s_cnt;
        w_m_eff_ext   = {{C_S_WIDTH{1'b0}}, w_m_eff};
        w_s_width_ext = {{C_M_WIDTH{1'b0}}, s_width};
        w_bad_last    = (s_axis.tlast != (w_s_idx_eff == (w_s_eff - 1'b1)));
    end

    // Hold register, counters, line bookkeeping and the length-error pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_v    <= 1'b0;
            r_hold_data <= '0;
            r_hold_user <= 1'b0;
            r_s_cnt     <= '0;
            r_m_cnt     <= '0;
            r_s_idx     <= '0;
            r_m_idx     <= '0;
            r_s_l       <= '0;
            r_m_l       <= '0;
            r_err_len   <= 1'b0;
        end else begin
            r_err_len <= w_s_hs && w_bad_last;

            if (w_m_hs) begin
                r_m_cnt <= r_m_cnt + w_s_l_ext;
                r_m_idx <= r_m_idx + 1'b1;
            end

            if (w_release) begin
                r_hold_v <= 1'b0;
            end

            if (w_line_end) begin
                r_s_cnt <= '0;
                r_m_cnt <= '0;
                r_s_idx <= '0;
                r_m_idx <= '0;
            end

            // A newly accepted pixel overrides any release or line-end clear.
            if (w_s_hs) begin
                r_hold_v    <= 1'b1;
                r_hold_data <= s_axis.tdata;
                r_s_cnt     <= w_s_cnt_base + w_m_eff_ext;
                r_s_idx     <= w_s_idx_eff + 1'b1;
                if (w_line_start) begin
                    r_s_l       <= s_width;
                    r_m_l       <= m_width;
                    r_m_cnt     <= w_s_width_ext;
                    r_m_idx     <= '0;
                    r_hold_user <= s_axis.tuser;
                end
            end
        end
    end

    assign s_axis.tready = w_s_ready;
    assign m_axis.tvalid = w_m_valid;
    assign m_axis.tdata  = r_hold_data;
    assign m_axis.tuser  = r_hold_v && r_hold_user && (r_m_idx == '0);
    assign m_axis.tlast  = r_hold_v && w_last_out;
    assign m_index       = r_m_idx;
    assign err_len       = r_err_len;

endmodule
`default_nettype wire

// File: tb/tb_scale_1d_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scale_1d_stream
//  Description : Self-checking bench for scale_1d_stream. Expected outputs
//                come from the nearest-neighbour pairing rule
//                i = ceil((j+1)*S/M)-1 applied to randomly generated lines.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scale_1d_stream;
    localparam int PW = 24;
    localparam int SW = 10;
    localparam int MW = 12;

    typedef struct {
        logic [PW-1:0] data;
        logic          user;
        logic          last;
        int            idx;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [SW-1:0] s_width;
    logic [MW-1:0] m_width;
    logic [MW-1:0] m_index;
    logic          err_len;
    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    exp_t          exp_q[$];
    bit            err_at[int];

    scale_1d_stream_if #(.C_PIXEL_WIDTH(PW)) s_if ();
    scale_1d_stream_if #(.C_PIXEL_WIDTH(PW)) m_if ();

    scale_1d_stream #(
        .C_PIXEL_WIDTH(PW),
        .C_S_WIDTH    (SW),
        .C_M_WIDTH    (MW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .s_width(s_width),
        .m_width(m_width),
        .s_axis (s_if),
        .m_axis (m_if),
        .m_index(m_index),
        .err_len(err_len)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stream nl lines of sw pixels and check nl*mw outputs against the model.
    task automatic run_lines(input int nl, input int sw, input int mw, input bit sof,
                             input bit src_stall, input bit snk_stall, input int stall_at,
                             input int exp_low, input int bad_last);
        logic [PW-1:0] pix[$];
        bit            tlq[$];
        bit            tuq[$];
        int            total, acc_first, first_v, low, got, budget;
        exp_q.delete();
        err_at.delete();
        acc_first = -1; first_v = -1; low = 0; got = 0;
        total  = nl * mw;
        budget = 50 + nl * (sw + mw) * 8;
        for (int l = 0; l < nl; l++) begin
            for (int i = 0; i < sw; i++) begin
                pix.push_back(PW'($urandom));
                tuq.push_back(sof && l == 0 && i == 0);
                tlq.push_back((i == sw - 1) ^ (i == bad_last));
            end
            for (int j = 0; j < mw; j++) begin
                int   src;
                exp_t e;
                src    = ((j + 1) * sw + mw - 1) / mw - 1;
                e.data = pix[l * sw + src];
                e.user = sof && l == 0 && j == 0;
                e.last = (j == mw - 1);
                e.idx  = j;
                exp_q.push_back(e);
            end
        end
        fork
            begin : source
                for (int k = 0; k < pix.size(); k++) begin
                    int tries;
                    bit acc;
                    if (src_stall) begin
                        repeat ($urandom_range(0, 2)) begin
                            @(negedge clk);
                            s_if.tvalid = 1'b0;
                        end
                    end
                    acc = 0; tries = 0;
                    while (!acc && tries < budget) begin
                        @(negedge clk);
                        s_if.tvalid = 1'b1;
                        s_if.tdata  = pix[k];
                        s_if.tuser  = tuq[k];
                        s_if.tlast  = tlq[k];
                        // Width inputs are garbage mid-line; only the line start counts.
                        if ((k % sw) != 0 && (k % sw) != sw - 1) begin
                            s_width = SW'($urandom);
                            m_width = MW'($urandom);
                        end else begin
                            s_width = SW'(sw);
                            m_width = MW'(mw);
                        end
                        #1;
                        tries++;
                        if (s_if.tready) begin
                            acc = 1;
                            if (acc_first < 0) acc_first = cyc;
                            if (tlq[k] != ((k % sw) == sw - 1)) err_at[cyc + 1] = 1'b1;
                        end
                    end
                    if (!acc) begin
                        check("src_accept", 32'(acc), 32'd1);
                        break;
                    end
                end
                @(negedge clk);
                s_if.tvalid = 1'b0;
                s_if.tuser  = 1'b0;
                s_if.tlast  = 1'b0;
                s_width     = SW'(sw);
                m_width     = MW'(mw);
            end
            begin : sink
                int            n, stall_cnt;
                bit            pv, pr, pu, pl;
                logic [PW-1:0] pd;
                logic [MW-1:0] pi;
                n = 0; stall_cnt = 0; pv = 0; pr = 1; pu = 0; pl = 0; pd = '0; pi = '0;
                while (got < total && n < budget) begin
                    @(negedge clk);
                    m_if.tready = snk_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
                    if (stall_at >= 0 && got == stall_at && stall_cnt < 3) begin
                        m_if.tready = 1'b0;
                        stall_cnt++;
                    end
                    #1;
                    n++;
                    check("err_len", 32'(err_len), 32'(err_at.exists(cyc)));
                    if (first_v < 0 && m_if.tvalid) first_v = cyc;
                    if (acc_first >= 0 && !s_if.tready) low++;
                    if (pv && !pr) begin
                        check("stall_valid", 32'(m_if.tvalid), 32'd1);
                        check("stall_data",  32'(m_if.tdata), 32'(pd));
                        check("stall_index", 32'(m_index), 32'(pi));
                        check("stall_last",  32'(m_if.tlast), 32'(pl));
                        check("stall_user",  32'(m_if.tuser), 32'(pu));
                    end
                    if (m_if.tvalid && !m_if.tready) check("stall_s_ready", 32'(s_if.tready), 32'd0);
                    if (m_if.tvalid && m_if.tready) begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("out_data",  32'(m_if.tdata), 32'(e.data));
                        check("out_index", 32'(m_index), 32'(e.idx));
                        check("out_last",  32'(m_if.tlast), 32'(e.last));
                        check("out_user",  32'(m_if.tuser), 32'(e.user));
                        got++;
                    end
                    pv = m_if.tvalid; pr = m_if.tready; pd = m_if.tdata;
                    pi = m_index; pl = m_if.tlast; pu = m_if.tuser;
                end
                if (got < total) check("out_count", 32'(got), 32'(total));
            end
        join
        if (sw <= mw && acc_first >= 0) check("latency", 32'(first_v - acc_first), 32'd1);
        if (exp_low >= 0) check("ready_low_cycles", 32'(low), 32'(exp_low));
        @(negedge clk);
        #1;
        check("idle_valid", 32'(m_if.tvalid), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        s_width = SW'(4); m_width = MW'(4);
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tuser = 1'b0; s_if.tlast = 1'b0;
        m_if.tready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_s_ready", 32'(s_if.tready), 32'd0);
        check("rst_m_valid", 32'(m_if.tvalid), 32'd0);
        check("rst_m_data",  32'(m_if.tdata), 32'd0);
        check("rst_m_last",  32'(m_if.tlast), 32'd0);
        check("rst_m_user",  32'(m_if.tuser), 32'd0);
        check("rst_m_index", 32'(m_index), 32'd0);
        check("rst_err_len", 32'(err_len), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("post_rst_s_ready", 32'(s_if.tready), 32'd1);

        // Unity, upscale, downscale, backpressure
        run_lines(1, 4, 4, 1'b1, 1'b0, 1'b0, -1, 0, -1);
        run_lines(1, 2, 5, 1'b0, 1'b0, 1'b0, -1, 3, -1);
        run_lines(1, 5, 2, 1'b0, 1'b0, 1'b0, -1, 0, -1);
        run_lines(1, 3, 6, 1'b0, 1'b0, 1'b0, 2, -1, -1);

        // Framing: SOF on first line only, back-to-back lines, width change
        run_lines(3, 4, 3, 1'b1, 1'b0, 1'b0, -1, -1, -1);
        run_lines(2, 2, 4, 1'b0, 1'b0, 1'b0, -1, -1, -1);

        // Length error: tlast on pixel 1 of a 4-pixel line
        run_lines(1, 4, 4, 1'b0, 1'b0, 1'b0, -1, -1, 1);

        // Mid-line reset
        s_width = SW'(4); m_width = MW'(4);
        repeat (3) begin
            @(negedge clk);
            s_if.tvalid = 1'b1;
            s_if.tdata  = PW'($urandom);
        end
        @(negedge clk);
        s_if.tvalid = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst_m_valid", 32'(m_if.tvalid), 32'd0);
        check("midrst_m_index", 32'(m_index), 32'd0);
        check("midrst_s_ready", 32'(s_if.tready), 32'd0);
        check("midrst_m_data",  32'(m_if.tdata), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_lines(1, 4, 4, 1'b1, 1'b0, 1'b0, -1, 0, -1);

        // Zero width at line start blocks the input
        @(negedge clk);
        s_width = '0; m_width = MW'(4);
        s_if.tvalid = 1'b1;
        #1;
        check("zero_s_ready", 32'(s_if.tready), 32'd0);
        @(negedge clk);
        s_width = SW'(3); m_width = '0;
        #1;
        check("zero_m_ready", 32'(s_if.tready), 32'd0);
        check("zero_m_valid", 32'(m_if.tvalid), 32'd0);
        @(negedge clk);
        s_if.tvalid = 1'b0;
        run_lines(1, 3, 4, 1'b0, 1'b0, 1'b0, -1, -1, -1);

        // Randomized geometries with source and sink stalls
        for (int t = 0; t < 8; t++) begin
            run_lines($urandom_range(1, 3), $urandom_range(1, 12), $urandom_range(1, 12),
                      1'($urandom), 1'b1, 1'b1, -1, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
